// File: rtl/sram_arbiter.sv
// Two-port round-robin arbiter in front of a single-port synchronous SRAM.
// Each transaction gets a one-cycle grant; reads return data two cycles after the grant.
module sram_arbiter #(
    parameter int WIDTH = 32,
    parameter int AW    = 8
) (
    input  logic             clk,
    input  logic             res,
    input  logic             req0,
    input  logic             req1,
    input  logic             we0,
    input  logic             we1,
    input  logic [AW-1:0]    addr0,
    input  logic [AW-1:0]    addr1,
    input  logic [WIDTH-1:0] wdata0,
    input  logic [WIDTH-1:0] wdata1,
    output logic             gnt0,
    output logic             gnt1,
    output logic             rvalid0,
    output logic             rvalid1,
    output logic [WIDTH-1:0] rdata0,
    output logic [WIDTH-1:0] rdata1,
    output logic             busy,
    output logic             sram_we,
    output logic [AW-1:0]    sram_addr,
    output logic [WIDTH-1:0] sram_din,
    input  logic [WIDTH-1:0] sram_dout
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RDATA  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic               lp_q, lp_d;
    logic               gnt0_q, gnt0_d;
    logic               gnt1_q, gnt1_d;
    logic               rvalid0_q, rvalid0_d;
    logic               rvalid1_q, rvalid1_d;
    logic [WIDTH-1:0]   rdata0_q, rdata0_d;
    logic [WIDTH-1:0]   rdata1_q, rdata1_d;
    logic               busy_q, busy_d;
    logic               sram_we_q, sram_we_d;
    logic [AW-1:0]      sram_addr_q, sram_addr_d;
    logic [WIDTH-1:0]   sram_din_q, sram_din_d;
    logic               sel;

    // lp doubles as the owner of the in-flight transaction, since it is set on selection.
    always_comb begin
        state_d     = state_q;
        lp_d        = lp_q;
        gnt0_d      = 1'b0;
        gnt1_d      = 1'b0;
        rvalid0_d   = 1'b0;
        rvalid1_d   = 1'b0;
        rdata0_d    = rdata0_q;
        rdata1_d    = rdata1_q;
        sram_we_d   = 1'b0;
        sram_addr_d = sram_addr_q;
        sram_din_d  = sram_din_q;
        sel         = lp_q;

        case (state_q)
            IDLE: begin
                if (req0 || req1) begin
                    if (req0 && req1) begin
                        sel = ~lp_q;
                    end else begin
                        sel = req1;
                    end
                    state_d     = ACCESS;
                    lp_d        = sel;
                    gnt0_d      = ~sel;
                    gnt1_d      = sel;
                    sram_we_d   = sel ? we1 : we0;
                    sram_addr_d = sel ? addr1 : addr0;
                    sram_din_d  = sel ? wdata1 : wdata0;
                end
            end
            ACCESS: begin
                state_d = sram_we_q ? IDLE : RDATA;
            end
            RDATA: begin
                state_d = IDLE;
                if (lp_q) begin
                    rvalid1_d = 1'b1;
                    rdata1_d  = sram_dout;
                end else begin
                    rvalid0_d = 1'b1;
                    rdata0_d  = sram_dout;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            state_q     <= IDLE;
            lp_q        <= 1'b1;
            gnt0_q      <= 1'b0;
            gnt1_q      <= 1'b0;
            rvalid0_q   <= 1'b0;
            rvalid1_q   <= 1'b0;
            rdata0_q    <= '0;
            rdata1_q    <= '0;
            busy_q      <= 1'b0;
            sram_we_q   <= 1'b0;
            sram_addr_q <= '0;
            sram_din_q  <= '0;
        end else begin
            state_q     <= state_d;
            lp_q        <= lp_d;
            gnt0_q      <= gnt0_d;
            gnt1_q      <= gnt1_d;
            rvalid0_q   <= rvalid0_d;
            rvalid1_q   <= rvalid1_d;
            rdata0_q    <= rdata0_d;
            rdata1_q    <= rdata1_d;
            busy_q      <= busy_d;
            sram_we_q   <= sram_we_d;
            sram_addr_q <= sram_addr_d;
            sram_din_q  <= sram_din_d;
        end
    end

    assign gnt0      = gnt0_q;
    assign gnt1      = gnt1_q;
    assign rvalid0   = rvalid0_q;
    assign rvalid1   = rvalid1_q;
    assign rdata0    = rdata0_q;
    assign rdata1    = rdata1_q;
    assign busy      = busy_q;
    assign sram_we   = sram_we_q;
    assign sram_addr = sram_addr_q;
    assign sram_din  = sram_din_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Scoreboard bench for sram_arbiter: a transaction-level model predicts every grant and
// read return; a monitor compares them as the DUT presents gnt/rvalid.
module tb_sram_arbiter;

    localparam int WIDTH = 32;
    localparam int AW    = 8;

    typedef struct {
        logic             we;
        logic [AW-1:0]    addr;
        logic [WIDTH-1:0] data;
    } txn_t;

    typedef struct {
        int               port;
        int               cyc;
        logic             we;
        logic [AW-1:0]    addr;
        logic [WIDTH-1:0] din;
    } gexp_t;

    typedef struct {
        int               port;
        int               cyc;
        logic [WIDTH-1:0] data;
    } rexp_t;

    logic             clk = 1'b0;
    logic             res = 1'b1;
    logic             req0 = 1'b0, req1 = 1'b0;
    logic             we0 = 1'b0, we1 = 1'b0;
    logic [AW-1:0]    addr0 = '0, addr1 = '0;
    logic [WIDTH-1:0] wdata0 = '0, wdata1 = '0;
    logic             gnt0, gnt1, rvalid0, rvalid1, busy, sram_we;
    logic [WIDTH-1:0] rdata0, rdata1, sram_din;
    logic [AW-1:0]    sram_addr;
    logic [WIDTH-1:0] sram_dout = '0;

    logic [WIDTH-1:0] sram_mem [0:(1<<AW)-1];
    logic [WIDTH-1:0] ref_mem  [0:(1<<AW)-1];

    txn_t  q0[$], q1[$];
    gexp_t exp_gnt[$];
    rexp_t exp_rd[$];

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int free_cyc = 0;
    int sel_n = 0;
    bit lp_m = 1'b1;
    bit act0 = 1'b0, act1 = 1'b0;
    bit taken0 = 1'b0, taken1 = 1'b0;
    bit gap_en = 1'b0;
    int gnt_cnt [2];
    int rv_cnt [2];
    int last_gnt_port = -1;
    logic [WIDTH-1:0] exp_last0 = '0, exp_last1 = '0;

    sram_arbiter #(.WIDTH(WIDTH), .AW(AW)) dut (
        .clk(clk), .res(res),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
        .rdata0(rdata0), .rdata1(rdata1), .busy(busy),
        .sram_we(sram_we), .sram_addr(sram_addr), .sram_din(sram_din),
        .sram_dout(sram_dout)
    );

    always #5 clk = ~clk;

    // Synchronous single-port SRAM: data for the address presented appears after the edge.
    always @(posedge clk) begin
        if (sram_we) sram_mem[sram_addr] <= sram_din;
        sram_dout <= sram_mem[sram_addr];
    end

    function automatic void checkOutput(string name, logic [WIDTH-1:0] act, logic [WIDTH-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    task automatic applyStimulus(input int port, input logic we, input logic [AW-1:0] addr,
                                 input logic [WIDTH-1:0] data);
        txn_t t;
        t.we = we; t.addr = addr; t.data = data;
        if (port == 0) q0.push_back(t); else q1.push_back(t);
    endtask

    // Reference model: a request seen while the arbiter is free is served in whole;
    // writes occupy 2 edges, reads 3; ties go to the port that was not served last.
    always @(posedge clk) begin
        int p;
        gexp_t g;
        rexp_t r;
        cyc++;
        if (res) begin
            free_cyc = cyc + 1;
            lp_m = 1'b1;
            exp_gnt.delete();
            exp_rd.delete();
            exp_last0 = '0;
            exp_last1 = '0;
        end else if (cyc >= free_cyc && (req0 || req1)) begin
            if (req0 && req1) p = lp_m ? 0 : 1;
            else p = req1 ? 1 : 0;
            lp_m = (p == 1);
            g.port = p;
            g.cyc  = cyc;
            g.we   = (p == 1) ? we1 : we0;
            g.addr = (p == 1) ? addr1 : addr0;
            g.din  = (p == 1) ? wdata1 : wdata0;
            exp_gnt.push_back(g);
            if (g.we) begin
                ref_mem[g.addr] = g.din;
                free_cyc = cyc + 2;
            end else begin
                r.port = p;
                r.cyc  = cyc + 2;
                r.data = ref_mem[g.addr];
                exp_rd.push_back(r);
                free_cyc = cyc + 3;
            end
            if (p == 1) taken1 = 1'b1; else taken0 = 1'b1;
            sel_n++;
        end
    end

    // Requesters: hold a request until the model has served it, then scramble the fields.
    always @(negedge clk) begin
        txn_t t;
        if (taken0) begin
            taken0 = 1'b0; act0 = 1'b0; req0 = 1'b0;
            we0 = 1'($urandom); addr0 = AW'($urandom); wdata0 = $urandom;
        end
        if (taken1) begin
            taken1 = 1'b0; act1 = 1'b0; req1 = 1'b0;
            we1 = 1'($urandom); addr1 = AW'($urandom); wdata1 = $urandom;
        end
        if (!act0 && q0.size() > 0 && !(gap_en && $urandom_range(0, 3) == 0)) begin
            t = q0.pop_front();
            req0 = 1'b1; we0 = t.we; addr0 = t.addr; wdata0 = t.data; act0 = 1'b1;
        end
        if (!act1 && q1.size() > 0 && !(gap_en && $urandom_range(0, 3) == 0)) begin
            t = q1.pop_front();
            req1 = 1'b1; we1 = t.we; addr1 = t.addr; wdata1 = t.data; act1 = 1'b1;
        end
    end

    // Monitor: pops an expectation whenever the DUT shows a grant or a read return.
    always @(negedge clk) begin
        gexp_t g;
        rexp_t r;
        int p;
        if (!res) begin
            if (gnt0 && gnt1) begin
                checkOutput("gnt_both", {30'd0, gnt1, gnt0}, 32'd1);
            end else if (gnt0 || gnt1) begin
                p = gnt1 ? 1 : 0;
                gnt_cnt[p]++;
                last_gnt_port = p;
                if (exp_gnt.size() == 0) begin
                    checkOutput("gnt_unexpected", {31'd0, 1'b1}, 32'd0);
                end else begin
                    g = exp_gnt.pop_front();
                    checkOutput("gnt_port", p, g.port);
                    checkOutput("gnt_cycle", cyc, g.cyc);
                    checkOutput("gnt_sram_we", {31'd0, sram_we}, {31'd0, g.we});
                    checkOutput("gnt_sram_addr", {24'd0, sram_addr}, {24'd0, g.addr});
                    checkOutput("gnt_sram_din", sram_din, g.din);
                    checkOutput("gnt_busy", {31'd0, busy}, 32'd1);
                end
            end else begin
                checkOutput("sram_we_idle", {31'd0, sram_we}, 32'd0);
            end

            if (rvalid0 && rvalid1) begin
                checkOutput("rvalid_both", {30'd0, rvalid1, rvalid0}, 32'd1);
            end else if (rvalid0 || rvalid1) begin
                p = rvalid1 ? 1 : 0;
                rv_cnt[p]++;
                if (exp_rd.size() == 0) begin
                    checkOutput("rvalid_unexpected", {31'd0, 1'b1}, 32'd0);
                end else begin
                    r = exp_rd.pop_front();
                    checkOutput("rvalid_port", p, r.port);
                    checkOutput("rvalid_cycle", cyc, r.cyc);
                    if (p == 1) begin
                        checkOutput("rdata1", rdata1, r.data);
                        checkOutput("rdata0_kept", rdata0, exp_last0);
                        exp_last1 = r.data;
                    end else begin
                        checkOutput("rdata0", rdata0, r.data);
                        checkOutput("rdata1_kept", rdata1, exp_last1);
                        exp_last0 = r.data;
                    end
                end
            end
        end
    end

    task automatic waitIdle();
        int pend;
        bit done = 1'b0;
        for (int i = 0; i < 3000 && !done; i++) begin
            @(negedge clk);
            pend = q0.size() + q1.size() + int'(act0) + int'(act1) + exp_gnt.size() + exp_rd.size();
            if (pend == 0 && cyc >= free_cyc) done = 1'b1;
        end
        if (!done) checkOutput("timeout_idle", pend + 1, 0);
    endtask

    task automatic waitSelection();
        int n0 = sel_n;
        int i = 0;
        while (sel_n == n0 && i < 100) begin
            @(negedge clk);
            i++;
        end
        if (sel_n == n0) checkOutput("timeout_select", 1, 0);
    endtask

    initial begin
        int g_before, rv_before, tot;
        logic [AW-1:0] a;
        for (int i = 0; i < (1 << AW); i++) begin
            sram_mem[i] = '0;
            ref_mem[i]  = '0;
        end

        repeat (3) @(negedge clk);
        checkOutput("reset_gnt", {30'd0, gnt1, gnt0}, 32'd0);
        checkOutput("reset_rvalid", {30'd0, rvalid1, rvalid0}, 32'd0);
        checkOutput("reset_busy", {31'd0, busy}, 32'd0);
        checkOutput("reset_sram_we", {31'd0, sram_we}, 32'd0);
        checkOutput("reset_sram_addr", {24'd0, sram_addr}, 32'd0);
        checkOutput("reset_sram_din", sram_din, 32'd0);
        checkOutput("reset_rdata0", rdata0, 32'd0);
        checkOutput("reset_rdata1", rdata1, 32'd0);
        res = 1'b0;

        // Simultaneous writes from both ports: grants alternate starting at port 0.
        applyStimulus(0, 1'b1, 8'h10, 32'h1000_0000);
        applyStimulus(1, 1'b1, 8'h11, 32'h1100_0001);
        applyStimulus(0, 1'b1, 8'h12, 32'h1200_0002);
        applyStimulus(1, 1'b1, 8'h13, 32'h1300_0003);
        waitIdle();

        applyStimulus(0, 1'b1, 8'h05, 32'hA5A5_A5A5);
        waitIdle();
        applyStimulus(1, 1'b0, 8'h05, 32'h0);
        waitIdle();

        // Extreme addresses must not alias.
        applyStimulus(0, 1'b1, 8'hFF, 32'hFFFF_FFFF);
        applyStimulus(1, 1'b1, 8'h00, 32'h0000_0001);
        waitIdle();
        applyStimulus(1, 1'b0, 8'hFF, 32'h0);
        applyStimulus(0, 1'b0, 8'h00, 32'h0);
        waitIdle();

        // One-cycle read request on port 0 still completes.
        rv_before = rv_cnt[0];
        applyStimulus(0, 1'b0, 8'h12, 32'h0);
        waitIdle();
        checkOutput("oneshot_rvalid0_count", rv_cnt[0] - rv_before, 1);

        // A request withdrawn while the arbiter is busy is never granted.
        applyStimulus(1, 1'b0, 8'h10, 32'h0);
        waitSelection();
        g_before = gnt_cnt[0];
        req0 = 1'b1; we0 = 1'b1; addr0 = 8'h77; wdata0 = 32'hDEAD_BEEF;
        @(negedge clk);
        req0 = 1'b0;
        waitIdle();
        checkOutput("withdrawn_gnt0_count", gnt_cnt[0] - g_before, 0);

        // Randomized traffic, biased toward a few addresses and the extremes.
        gap_en = 1'b1;
        for (int i = 0; i < 60; i++) begin
            case ($urandom_range(0, 9))
                0: a = 8'h00;
                1: a = 8'hFF;
                default: a = AW'($urandom_range(1, 6));
            endcase
            applyStimulus($urandom_range(0, 1), 1'($urandom), a, $urandom);
        end
        waitIdle();
        gap_en = 1'b0;

        // Reset during RDATA of a port-0 read discards it; first tie afterwards goes to port 0.
        applyStimulus(1, 1'b0, 8'h30, 32'h0);
        waitIdle();
        applyStimulus(0, 1'b0, 8'hFF, 32'h0);
        waitSelection();
        @(negedge clk);
        rv_before = rv_cnt[0];
        res = 1'b1;
        #1;
        checkOutput("async_reset_busy", {31'd0, busy}, 32'd0);
        checkOutput("async_reset_rvalid0", {31'd0, rvalid0}, 32'd0);
        applyStimulus(0, 1'b1, 8'h20, 32'h2020_2020);
        applyStimulus(1, 1'b1, 8'h21, 32'h2121_2121);
        @(negedge clk);
        checkOutput("reset_next_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        res = 1'b0;
        tot = gnt_cnt[0] + gnt_cnt[1];
        for (int i = 0; i < 20 && (gnt_cnt[0] + gnt_cnt[1]) == tot; i++) @(negedge clk);
        checkOutput("first_tie_after_reset", last_gnt_port, 0);
        waitIdle();
        checkOutput("reset_rvalid0_count", rv_cnt[0] - rv_before, 0);
        applyStimulus(1, 1'b0, 8'h20, 32'h0);
        waitIdle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #300000;
        $display("[TB] FAIL watchdog: simulation did not finish (compared %0d)", n_cmp);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
